// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 control unit (package LCp).
// Holds the opcode and controller-state enums, the datapath select encodings,
// and the packed control-word struct that the controller drives.
// Optional feature macro: LC3_CTRL_INDIRECT_EN adds the IND_RD/IND_MAR states
// used by LDI/STI.
package LCp;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_t;

  // The indirect states only exist when the indirect feature is built in.
  typedef enum logic [4:0] {
    S_FETCH1  = 5'd0,
    S_FETCH2  = 5'd1,
    S_FETCH3  = 5'd2,
    S_DECODE  = 5'd3,
    S_ALU_EX  = 5'd4,
    S_BR_EX   = 5'd5,
    S_JMP_EX  = 5'd6,
    S_LEA_EX  = 5'd7,
    S_ADDR    = 5'd8,
    S_MEM_RD  = 5'd9,
    S_MEM_WB  = 5'd10,
    S_ST_MDR  = 5'd11,
    S_MEM_WR  = 5'd12,
    S_HALT    = 5'd13,
    S_ILLEGAL = 5'd14
`ifdef LC3_CTRL_INDIRECT_EN
    ,
    S_IND_RD  = 5'd15,
    S_IND_MAR = 5'd16
`endif
  } ctrl_state_t;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  // PC input mux
  localparam logic [1:0] PCMUX_INC     = 2'b00;
  localparam logic [1:0] PCMUX_ADDRSUM = 2'b01;
  localparam logic [1:0] PCMUX_BUS     = 2'b10;

  // Address adder operand 1
  localparam logic       ADDR1_PC    = 1'b0;
  localparam logic       ADDR1_BASER = 1'b1;

  // Address adder operand 2 (sign-extended offsets)
  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  // MAR mux
  localparam logic       MARMUX_ZEXT8   = 1'b0;
  localparam logic       MARMUX_ADDRSUM = 1'b1;

  // Complete control word; zero means "do nothing".
  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_cc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux_sel;
    logic       addr1_sel;
    logic [1:0] addr2_sel;
    logic       marmux_sel;
    logic [1:0] alu_op;
    logic       sr2_imm;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       mem_en;
    logic       mem_we;
    logic       halt;
    logic       illegal;
  } ctrl_out_t;

  // Opcode field of an instruction word
  function automatic opcode_t ir_opcode(input logic [15:0] ir);
    return opcode_t'(ir[15:12]);
  endfunction

endpackage

// File: rtl/lc3_ctrl_br_cond.sv
// LC-3 branch condition: taken when any requested flag (ir[11:9]) matches
// the current condition codes {N,Z,P}.
module lc3_br_cond (
  input  logic [2:0] cond,
  input  logic [2:0] nzp,
  output logic       taken
);

  assign taken = |(cond & nzp);

endmodule

// File: rtl/lc3_ctrl.sv
// LC-3 multicycle control unit: Moore FSM producing register loads, bus
// gates, mux selects and memory handshakes for the LC-3 datapath.
// Optional feature macro: LC3_CTRL_INDIRECT_EN (LDI/STI via IND_RD/IND_MAR;
// without it LDI/STI are treated as illegal instructions).
module lc3_ctrl
  import LCp::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_rdy,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pcmux_sel,
  output logic        addr1_sel,
  output logic [1:0]  addr2_sel,
  output logic        marmux_sel,
  output logic [1:0]  alu_op,
  output logic        sr2_imm,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [2:0]  dr,
  output logic        mem_en,
  output logic        mem_we,
  output logic        halt,
  output logic        illegal
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;
  ctrl_out_t   ctl_next;
  ctrl_out_t   ctl_out;
  opcode_t     op;
  logic        br_taken;
  logic        unused_ir_bits;

  assign op = ir_opcode(ir);
  // ir[4:3] carry no control meaning (ADD/AND padding, part of offsets).
  assign unused_ir_bits = ^ir[4:3];

  lc3_br_cond u_br_cond (
    .cond  (ir[11:9]),
    .nzp   (nzp),
    .taken (br_taken)
  );

  // State register; reset parks the machine at FETCH1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH1;
    else        state_reg <= state_next;
  end

  // Next-state logic; mem_rdy only matters in the memory wait states.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: if (mem_rdy) state_next = S_FETCH3;
      S_FETCH3: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT:        state_next = S_ALU_EX;
          OP_BR:                         state_next = S_BR_EX;
          OP_JMP, OP_JSR:                state_next = S_JMP_EX;
          OP_LEA:                        state_next = S_LEA_EX;
          OP_LD, OP_ST, OP_LDR, OP_STR:  state_next = S_ADDR;
`ifdef LC3_CTRL_INDIRECT_EN
          OP_LDI, OP_STI:                state_next = S_ADDR;
`endif
          OP_TRAP:                       state_next = S_HALT;
          default:                       state_next = S_ILLEGAL;
        endcase
      end
      S_ALU_EX, S_BR_EX, S_JMP_EX, S_LEA_EX, S_MEM_WB: state_next = S_FETCH1;
      S_ADDR: begin
        case (op)
          OP_LD, OP_LDR:                 state_next = S_MEM_RD;
          OP_ST, OP_STR:                 state_next = S_ST_MDR;
`ifdef LC3_CTRL_INDIRECT_EN
          OP_LDI, OP_STI:                state_next = S_IND_RD;
`endif
          default:                       state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_RD: if (mem_rdy) state_next = S_MEM_WB;
      S_ST_MDR: state_next = S_MEM_WR;
      S_MEM_WR: if (mem_rdy) state_next = S_FETCH1;
`ifdef LC3_CTRL_INDIRECT_EN
      S_IND_RD:  if (mem_rdy) state_next = S_IND_MAR;
      S_IND_MAR: state_next = (op == OP_LDI) ? S_MEM_RD : S_ST_MDR;
`endif
      S_HALT:    state_next = S_HALT;
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:   state_next = S_ILLEGAL;
    endcase
  end

  // Control word decode per state (Moore, except ld_mdr on the mem_rdy cycle
  // and ld_pc on the branch outcome).
  always_comb begin
    ctl_next = '0;
    case (state_reg)
      S_FETCH1: begin
        ctl_next.gate_pc   = 1'b1;
        ctl_next.ld_mar    = 1'b1;
        ctl_next.ld_pc     = 1'b1;
        ctl_next.pcmux_sel = PCMUX_INC;
      end
      S_FETCH2, S_MEM_RD: begin
        ctl_next.mem_en = 1'b1;
        ctl_next.ld_mdr = mem_rdy;
      end
`ifdef LC3_CTRL_INDIRECT_EN
      S_IND_RD: begin
        ctl_next.mem_en = 1'b1;
        ctl_next.ld_mdr = mem_rdy;
      end
      S_IND_MAR: begin
        ctl_next.gate_mdr = 1'b1;
        ctl_next.ld_mar   = 1'b1;
      end
`endif
      S_FETCH3: begin
        ctl_next.gate_mdr = 1'b1;
        ctl_next.ld_ir    = 1'b1;
      end
      S_ALU_EX: begin
        ctl_next.gate_alu = 1'b1;
        ctl_next.ld_reg   = 1'b1;
        ctl_next.ld_cc    = 1'b1;
        ctl_next.dr       = ir[11:9];
        ctl_next.sr1      = ir[8:6];
        ctl_next.sr2      = ir[2:0];
        ctl_next.sr2_imm  = ir[5];
        case (op)
          OP_ADD:  ctl_next.alu_op = ALU_ADD;
          OP_AND:  ctl_next.alu_op = ALU_AND;
          default: ctl_next.alu_op = ALU_NOT;
        endcase
      end
      S_BR_EX: begin
        ctl_next.pcmux_sel = PCMUX_ADDRSUM;
        ctl_next.addr1_sel = ADDR1_PC;
        ctl_next.addr2_sel = ADDR2_OFF9;
        ctl_next.ld_pc     = br_taken;
      end
      S_JMP_EX: begin
        ctl_next.ld_pc     = 1'b1;
        ctl_next.pcmux_sel = PCMUX_ADDRSUM;
        ctl_next.sr1       = ir[8:6];
        ctl_next.addr1_sel = ADDR1_BASER;
        ctl_next.addr2_sel = ADDR2_ZERO;
        if (op == OP_JSR) begin
          // R7 captures the old PC off the bus on the same edge the PC jumps.
          ctl_next.gate_pc = 1'b1;
          ctl_next.ld_reg  = 1'b1;
          ctl_next.dr      = 3'd7;
          if (ir[11]) begin
            ctl_next.addr1_sel = ADDR1_PC;
            ctl_next.addr2_sel = ADDR2_OFF11;
          end
        end
      end
      S_LEA_EX: begin
        ctl_next.gate_marmux = 1'b1;
        ctl_next.marmux_sel  = MARMUX_ADDRSUM;
        ctl_next.addr1_sel   = ADDR1_PC;
        ctl_next.addr2_sel   = ADDR2_OFF9;
        ctl_next.ld_reg      = 1'b1;
        ctl_next.dr          = ir[11:9];
      end
      S_ADDR: begin
        ctl_next.ld_mar      = 1'b1;
        ctl_next.gate_marmux = 1'b1;
        ctl_next.marmux_sel  = MARMUX_ADDRSUM;
        if (op == OP_LDR || op == OP_STR) begin
          ctl_next.addr1_sel = ADDR1_BASER;
          ctl_next.addr2_sel = ADDR2_OFF6;
          ctl_next.sr1       = ir[8:6];
        end else begin
          ctl_next.addr1_sel = ADDR1_PC;
          ctl_next.addr2_sel = ADDR2_OFF9;
        end
      end
      S_ST_MDR: begin
        ctl_next.sr1      = ir[11:9];
        ctl_next.gate_alu = 1'b1;
        ctl_next.alu_op   = ALU_PASS;
        ctl_next.ld_mdr   = 1'b1;
      end
      S_MEM_WR: begin
        ctl_next.mem_en = 1'b1;
        ctl_next.mem_we = 1'b1;
      end
      S_MEM_WB: begin
        ctl_next.gate_mdr = 1'b1;
        ctl_next.ld_reg   = 1'b1;
        ctl_next.ld_cc    = 1'b1;
        ctl_next.dr       = ir[11:9];
      end
      S_HALT:    ctl_next.halt    = 1'b1;
      S_ILLEGAL: ctl_next.illegal = 1'b1;
      default:   ctl_next = '0;
    endcase
  end

  // Reset forces every output low immediately, even mid memory access.
  assign ctl_out = rst_n ? ctl_next : '0;

  assign ld_mar      = ctl_out.ld_mar;
  assign ld_mdr      = ctl_out.ld_mdr;
  assign ld_ir       = ctl_out.ld_ir;
  assign ld_pc       = ctl_out.ld_pc;
  assign ld_reg      = ctl_out.ld_reg;
  assign ld_cc       = ctl_out.ld_cc;
  assign gate_pc     = ctl_out.gate_pc;
  assign gate_mdr    = ctl_out.gate_mdr;
  assign gate_alu    = ctl_out.gate_alu;
  assign gate_marmux = ctl_out.gate_marmux;
  assign pcmux_sel   = ctl_out.pcmux_sel;
  assign addr1_sel   = ctl_out.addr1_sel;
  assign addr2_sel   = ctl_out.addr2_sel;
  assign marmux_sel  = ctl_out.marmux_sel;
  assign alu_op      = ctl_out.alu_op;
  assign sr2_imm     = ctl_out.sr2_imm;
  assign sr1         = ctl_out.sr1;
  assign sr2         = ctl_out.sr2;
  assign dr          = ctl_out.dr;
  assign mem_en      = ctl_out.mem_en;
  assign mem_we      = ctl_out.mem_we;
  assign halt        = ctl_out.halt;
  assign illegal     = ctl_out.illegal;

endmodule

// File: tb/tb_lc3_ctrl.sv
// Testbench for lc3_ctrl: table-driven per-cycle vectors with hand-computed
// control words, plus hand-written reset/halt/illegal/indirect sequences.
// Honours LC3_CTRL_INDIRECT_EN to select the expected LDI/STI behaviour.
module tb_lc3_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        mem_rdy;
  logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
  logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic [1:0]  pcmux_sel;
  logic        addr1_sel;
  logic [1:0]  addr2_sel;
  logic        marmux_sel;
  logic [1:0]  alu_op;
  logic        sr2_imm;
  logic [2:0]  sr1, sr2, dr;
  logic        mem_en, mem_we, halt, illegal;

  lc3_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .nzp(nzp), .mem_rdy(mem_rdy),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc),
    .ld_reg(ld_reg), .ld_cc(ld_cc), .gate_pc(gate_pc), .gate_mdr(gate_mdr),
    .gate_alu(gate_alu), .gate_marmux(gate_marmux), .pcmux_sel(pcmux_sel),
    .addr1_sel(addr1_sel), .addr2_sel(addr2_sel), .marmux_sel(marmux_sel),
    .alu_op(alu_op), .sr2_imm(sr2_imm), .sr1(sr1), .sr2(sr2), .dr(dr),
    .mem_en(mem_en), .mem_we(mem_we), .halt(halt), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control-word bit masks
  localparam logic [13:0] LM   = 14'h2000;
  localparam logic [13:0] LMDR = 14'h1000;
  localparam logic [13:0] LIR  = 14'h0800;
  localparam logic [13:0] LPC  = 14'h0400;
  localparam logic [13:0] LREG = 14'h0200;
  localparam logic [13:0] LCC  = 14'h0100;
  localparam logic [13:0] GPC  = 14'h0080;
  localparam logic [13:0] GMDR = 14'h0040;
  localparam logic [13:0] GALU = 14'h0020;
  localparam logic [13:0] GMM  = 14'h0010;
  localparam logic [13:0] MEN  = 14'h0008;
  localparam logic [13:0] MWE  = 14'h0004;
  localparam logic [13:0] HLT  = 14'h0002;
  localparam logic [13:0] ILL  = 14'h0001;

  logic [13:0] ctl_w;
  logic [17:0] sel_w;
  assign ctl_w = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, gate_pc, gate_mdr,
                  gate_alu, gate_marmux, mem_en, mem_we, halt, illegal};
  assign sel_w = {pcmux_sel, addr1_sel, addr2_sel, marmux_sel, alu_op, sr2_imm,
                  sr1, sr2, dr};

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        rdy;
    logic [13:0] ctl;
    logic [17:0] sel;
  } vec_t;

  vec_t vq[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   vec_no    = 0;

  function automatic logic [17:0] mk_sel(input logic [1:0] pm, input logic a1,
                                         input logic [1:0] a2, input logic mm,
                                         input logic [1:0] alu, input logic imm,
                                         input logic [2:0] s1, input logic [2:0] s2,
                                         input logic [2:0] d);
    return {pm, a1, a2, mm, alu, imm, s1, s2, d};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic v(input logic [15:0] i, input logic [2:0] n, input logic r,
                   input logic [13:0] c, input logic [17:0] s);
    vec_t e;
    e.ir = i; e.nzp = n; e.rdy = r; e.ctl = c; e.sel = s;
    vq.push_back(e);
  endtask

  // FETCH1, FETCH2 (ready at once), FETCH3, DECODE
  task automatic fetch(input logic [15:0] i);
    v(i, 3'b000, 1'b1, LM | LPC | GPC, 18'h0);
    v(i, 3'b000, 1'b1, MEN | LMDR,     18'h0);
    v(i, 3'b000, 1'b1, GMDR | LIR,     18'h0);
    v(i, 3'b000, 1'b1, 14'h0,          18'h0);
  endtask

  // Apply queued vectors one per cycle; compare at the falling edge.
  task automatic run_vecs();
    for (int k = 0; k < vq.size(); k++) begin
      ir = vq[k].ir; nzp = vq[k].nzp; mem_rdy = vq[k].rdy;
      @(negedge clk);
      check($sformatf("vec%0d ir=%h ctl", vec_no, vq[k].ir), {18'h0, ctl_w}, {18'h0, vq[k].ctl});
      check($sformatf("vec%0d ir=%h sel", vec_no, vq[k].ir), {14'h0, sel_w}, {14'h0, vq[k].sel});
      $display("vec %0d ir=%h nzp=%b rdy=%b ctl=%b sel=%h", vec_no, vq[k].ir,
               vq[k].nzp, vq[k].rdy, ctl_w, sel_w);
      vec_no++;
      @(posedge clk); #1;
    end
    vq.delete();
  endtask

  // Reset pulse: outputs must be zero while low; released just after an edge.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    check({nm, " ctl in reset"}, {18'h0, ctl_w}, 32'h0);
    check({nm, " sel in reset"}, {14'h0, sel_w}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ir = 16'h12A3; nzp = 3'b000; mem_rdy = 1'b1;
    #2;
    do_reset("initial");

    // ---- Main table: straight-line program ----
    fetch(16'h12A3);                                   // ADD R1,R2,#3
    v(16'h12A3, 3'b000, 1'b1, GALU | LREG | LCC, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 3'd2, 3'd3, 3'd1));
    fetch(16'h5946);                                   // AND R4,R5,R6
    v(16'h5946, 3'b000, 1'b0, GALU | LREG | LCC, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 3'd5, 3'd6, 3'd4));
    fetch(16'h91FF);                                   // NOT R0,R7
    v(16'h91FF, 3'b000, 1'b1, GALU | LREG | LCC, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 3'd7, 3'd7, 3'd0));
    fetch(16'h0402);                                   // BRz, Z set: taken
    v(16'h0402, 3'b010, 1'b1, LPC,   mk_sel(2'd1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0));
    fetch(16'h0402);                                   // BRz, N set: not taken
    v(16'h0402, 3'b100, 1'b1, 14'h0, mk_sel(2'd1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0));
    // LD R3 with a fetch wait and three MEM_RD wait cycles
    v(16'h2605, 3'b000, 1'b1, LM | LPC | GPC, 18'h0);
    v(16'h2605, 3'b000, 1'b0, MEN,        18'h0);
    v(16'h2605, 3'b000, 1'b1, MEN | LMDR, 18'h0);
    v(16'h2605, 3'b000, 1'b0, GMDR | LIR, 18'h0);
    v(16'h2605, 3'b000, 1'b0, 14'h0,      18'h0);
    v(16'h2605, 3'b000, 1'b1, LM | GMM,   mk_sel(2'd0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0));
    v(16'h2605, 3'b000, 1'b0, MEN,        18'h0);
    v(16'h2605, 3'b000, 1'b0, MEN,        18'h0);
    v(16'h2605, 3'b000, 1'b0, MEN,        18'h0);
    v(16'h2605, 3'b000, 1'b1, MEN | LMDR, 18'h0);
    v(16'h2605, 3'b000, 1'b1, GMDR | LREG | LCC, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd3));
    fetch(16'h7A81);                                   // STR R5,R2,#1
    v(16'h7A81, 3'b000, 1'b1, LM | GMM,   mk_sel(2'd0, 1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 3'd2, 3'd0, 3'd0));
    v(16'h7A81, 3'b000, 1'b1, LMDR | GALU, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 3'd5, 3'd0, 3'd0));
    v(16'h7A81, 3'b000, 1'b0, MEN | MWE,  18'h0);
    v(16'h7A81, 3'b000, 1'b1, MEN | MWE,  18'h0);
    fetch(16'h6C7F);                                   // LDR R6,R1,#-1
    v(16'h6C7F, 3'b000, 1'b1, LM | GMM,   mk_sel(2'd0, 1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 3'd1, 3'd0, 3'd0));
    v(16'h6C7F, 3'b000, 1'b1, MEN | LMDR, 18'h0);
    v(16'h6C7F, 3'b000, 1'b1, GMDR | LREG | LCC, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd6));
    fetch(16'hE405);                                   // LEA R2
    v(16'hE405, 3'b000, 1'b1, GMM | LREG, mk_sel(2'd0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0, 3'd2));
    fetch(16'hC0C0);                                   // JMP R3
    v(16'hC0C0, 3'b000, 1'b1, LPC,        mk_sel(2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 3'd3, 3'd0, 3'd0));
    fetch(16'h4805);                                   // JSR +5
    v(16'h4805, 3'b000, 1'b1, LPC | GPC | LREG, mk_sel(2'd1, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd7));
    fetch(16'h4100);                                   // JSRR R4
    v(16'h4100, 3'b000, 1'b1, LPC | GPC | LREG, mk_sel(2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 3'd4, 3'd0, 3'd7));
    v(16'h4100, 3'b000, 1'b1, LM | LPC | GPC, 18'h0);  // back at FETCH1
    run_vecs();

    // ---- Reset asserted while ST waits in MEM_WR ----
    do_reset("pre-st");
    fetch(16'h3001);
    v(16'h3001, 3'b000, 1'b1, LM | GMM,    mk_sel(2'd0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0));
    v(16'h3001, 3'b000, 1'b1, LMDR | GALU, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 3'd0, 3'd0, 3'd0));
    v(16'h3001, 3'b000, 1'b0, MEN | MWE,   18'h0);
    run_vecs();
    mem_rdy = 1'b0;
    #2;
    check("st mem_wr still pending", {18'h0, ctl_w}, {18'h0, MEN | MWE});
    do_reset("st mem_wr abort");
    fetch(16'h3001);                                   // resumes at FETCH1
    run_vecs();

    // ---- TRAP: halt sticks until reset ----
    do_reset("pre-trap");
    fetch(16'hF025);
    v(16'hF025, 3'b000, 1'b1, HLT, 18'h0);
    v(16'hF025, 3'b111, 1'b0, HLT, 18'h0);
    v(16'h12A3, 3'b000, 1'b1, HLT, 18'h0);
    run_vecs();
    do_reset("after halt");

    // ---- RESERVED and RTI are illegal ----
    fetch(16'hD000);
    v(16'hD000, 3'b000, 1'b1, ILL, 18'h0);
    v(16'hD000, 3'b000, 1'b0, ILL, 18'h0);
    run_vecs();
    do_reset("after reserved");
    fetch(16'h8000);
    v(16'h8000, 3'b000, 1'b1, ILL, 18'h0);
    run_vecs();
    do_reset("after rti");

    // ---- LDI / STI ----
`ifdef LC3_CTRL_INDIRECT_EN
    fetch(16'hA201);
    v(16'hA201, 3'b000, 1'b1, LM | GMM,   mk_sel(2'd0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0));
    v(16'hA201, 3'b000, 1'b0, MEN,        18'h0);
    v(16'hA201, 3'b000, 1'b1, MEN | LMDR, 18'h0);
    v(16'hA201, 3'b000, 1'b1, GMDR | LM,  18'h0);
    v(16'hA201, 3'b000, 1'b1, MEN | LMDR, 18'h0);
    v(16'hA201, 3'b000, 1'b1, GMDR | LREG | LCC, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 3'd1));
    fetch(16'hB201);
    v(16'hB201, 3'b000, 1'b1, LM | GMM,   mk_sel(2'd0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0));
    v(16'hB201, 3'b000, 1'b1, MEN | LMDR, 18'h0);
    v(16'hB201, 3'b000, 1'b1, GMDR | LM,  18'h0);
    v(16'hB201, 3'b000, 1'b1, LMDR | GALU, mk_sel(2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 3'd1, 3'd0, 3'd0));
    v(16'hB201, 3'b000, 1'b1, MEN | MWE,  18'h0);
    v(16'hB201, 3'b000, 1'b1, LM | LPC | GPC, 18'h0);
    run_vecs();
`else
    fetch(16'hA201);
    v(16'hA201, 3'b000, 1'b1, ILL, 18'h0);
    v(16'hA201, 3'b000, 1'b1, ILL, 18'h0);
    run_vecs();
    do_reset("after ldi");
    fetch(16'hB201);
    v(16'hB201, 3'b000, 1'b1, ILL, 18'h0);
    run_vecs();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
